// File: rtl/gf180mcu_osu_sc_char_pkg.sv
// Shared types and defaults for the gf180mcu OSU standard-cell characterization blocks.
package gf180mcu_osu_sc_char_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_COUNT, ST_DONE} char_state_e;

  localparam int CNT_W_DEF       = 16;
  localparam int WIN_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int STUCK_LIMIT_DEF = 32;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Out-of-range stage counts are pulled back into the supported range.
  function automatic int clamp_stages(input int s);
    if (s < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
    if (s > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
    return s;
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_12t_sync_rise.sv
// Synchronizer chain for an asynchronous cell output plus a prev flop; flags a rising edge.
module gf180mcu_osu_sc_12t_sync_rise
  import gf180mcu_osu_sc_char_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  localparam int N = clamp_stages(STAGES);

  logic [N-1:0] sync_q;
  logic         prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[N-2:0], sig};
      prev_q <= sync_q[N-1];
    end
  end

  assign rise = sync_q[N-1] & ~prev_q;

endmodule

// File: rtl/gf180mcu_osu_sc_12t_edge_count.sv
// Windowed rising-edge counter for on-silicon toggle/frequency characterization of library cells.
// Optional stuck-input detection is built when OSU_SC_STUCK_DET_EN is defined.
module gf180mcu_osu_sc_12t_edge_count
  import gf180mcu_osu_sc_char_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WIN_W       = WIN_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
`ifdef OSU_SC_STUCK_DET_EN
  , parameter int STUCK_LIMIT = STUCK_LIMIT_DEF
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIN_W-1:0] WIN_LEN,
  input  logic             SIG,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF
`ifdef OSU_SC_STUCK_DET_EN
  , output logic           STUCK
`endif
);

  localparam int              STG         = clamp_stages(SYNC_STAGES);
  localparam logic [2:0]      SETTLE_LAST = 3'(STG - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  char_state_e      state_q, state_d;
  logic [WIN_W-1:0] win_q;
  logic [2:0]       settle_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             rise;
  logic             start_acc;

  gf180mcu_osu_sc_12t_sync_rise #(.STAGES(STG)) u_sync (
    .clk  (CLK),
    .rst  (RST),
    .sig  (SIG),
    .rise (rise)
  );

  assign start_acc = (state_q == ST_IDLE) && START;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (START) state_d = ST_SETTLE;
      // A zero-length window skips counting entirely.
      ST_SETTLE: if (settle_q == SETTLE_LAST)
                   state_d = (win_q == '0) ? ST_DONE : ST_COUNT;
      ST_COUNT:  if (win_q <= WIN_W'(1)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (START) begin
          win_q    <= WIN_LEN;
          settle_q <= '0;
          cnt_q    <= '0;
          ovf_q    <= 1'b0;
        end
        ST_SETTLE: settle_q <= settle_q + 3'd1;
        ST_COUNT: begin
          if (win_q != '0) win_q <= win_q - WIN_W'(1);
          // Saturate rather than wrap; the lost edge is recorded in OVF.
          if (rise) begin
            if (cnt_q == CNT_MAX) ovf_q <= 1'b1;
            else                  cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY  = (state_q == ST_SETTLE) || (state_q == ST_COUNT);
  assign DONE  = (state_q == ST_DONE);
  assign COUNT = cnt_q;
  assign OVF   = ovf_q;

`ifdef OSU_SC_STUCK_DET_EN
  localparam int           SW        = $clog2(STUCK_LIMIT + 1);
  localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_LIMIT);

  logic [SW-1:0] stuck_cnt_q;
  logic          stuck_q;

  // Counts COUNT-state cycles since the last rise; stops at the limit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stuck_cnt_q <= '0;
      stuck_q     <= 1'b0;
    end else if (start_acc) begin
      stuck_cnt_q <= '0;
      stuck_q     <= 1'b0;
    end else if (state_q == ST_COUNT) begin
      if (rise) stuck_cnt_q <= '0;
      else if (stuck_cnt_q != STUCK_MAX) begin
        stuck_cnt_q <= stuck_cnt_q + SW'(1);
        if (stuck_cnt_q + SW'(1) == STUCK_MAX) stuck_q <= 1'b1;
      end
    end
  end

  assign STUCK = stuck_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_edge_count.sv
// Bench for the windowed edge counter: a sample-history model checked every cycle plus directed literals.
module tb_gf180mcu_osu_sc_12t_edge_count;

  localparam int S     = 2;
  localparam int LIMIT = 32;

  logic        clk = 1'b0;
  logic        rst, start, sig;
  logic [15:0] win_len;
  logic        busy, done, ovf, busy4, done4, ovf4;
  logic [15:0] count;
  logic [3:0]  count4;
`ifdef OSU_SC_STUCK_DET_EN
  logic        stuck, stuck4;
`endif

  always #5 clk = ~clk;

  gf180mcu_osu_sc_12t_edge_count #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(S)
`ifdef OSU_SC_STUCK_DET_EN
    , .STUCK_LIMIT(LIMIT)
`endif
  ) dut (
    .CLK(clk), .RST(rst), .START(start), .WIN_LEN(win_len), .SIG(sig),
    .BUSY(busy), .DONE(done), .COUNT(count), .OVF(ovf)
`ifdef OSU_SC_STUCK_DET_EN
    , .STUCK(stuck)
`endif
  );

  gf180mcu_osu_sc_12t_edge_count #(.CNT_W(4), .WIN_W(16), .SYNC_STAGES(S)
`ifdef OSU_SC_STUCK_DET_EN
    , .STUCK_LIMIT(LIMIT)
`endif
  ) dut4 (
    .CLK(clk), .RST(rst), .START(start), .WIN_LEN(win_len), .SIG(sig),
    .BUSY(busy4), .DONE(done4), .COUNT(count4), .OVF(ovf4)
`ifdef OSU_SC_STUCK_DET_EN
    , .STUCK(stuck4)
`endif
  );

  int errs = 0, checks = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // SIG source: fixed level, or a square wave of the given period.
  int sig_period = 0, ph = 0;
  bit sig_level = 1'b0;
  always @(negedge clk) begin
    if (sig_period == 0) begin
      sig = sig_level;
      ph  = 0;
    end else begin
      ph++;
      if (ph >= sig_period / 2) begin
        sig = ~sig;
        ph  = 0;
      end
    end
  end

  // Model: the count of a window started at edge e0 is the number of 0->1
  // transitions in the SIG samples taken at edges e0..e0+WIN_LEN.
  int cyc = 0, last_rst = -1, e0 = 0, wl = 0, idle_from = 0, m_raw = 0;
  bit hist [0:16383];
  bit m_active = 1'b0, m_done = 1'b0, m_stuck = 1'b0, mvalid = 1'b0;

  function automatic bit smp(input int k);
    return (k > last_rst) ? hist[k] : 1'b0;
  endfunction

  function automatic longint sat(input int raw, input int w);
    longint mx = (64'd1 << w) - 1;
    return (raw > mx) ? mx : raw;
  endfunction

  always @(posedge clk) begin
    cyc++;
    hist[cyc] = sig;
    m_done = 1'b0;
    if (rst) begin
      last_rst = cyc; m_active = 1'b0; m_raw = 0; m_stuck = 1'b0;
      idle_from = cyc + 1; mvalid = 1'b1;
    end else if (m_active && cyc == e0 + S + wl) begin
      int run;
      run = 0; m_raw = 0; m_stuck = 1'b0;
      for (int j = 0; j < wl; j++) begin
        if (smp(e0 + j + 1) && !smp(e0 + j)) begin m_raw++; run = 0; end
        else begin run++; if (run >= LIMIT) m_stuck = 1'b1; end
      end
      m_active = 1'b0; m_done = 1'b1; idle_from = cyc + 2;
    end else if (!m_active && cyc >= idle_from && start) begin
      m_active = 1'b1; e0 = cyc; wl = int'(win_len); m_raw = 0; m_stuck = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("busy",  busy,  m_active);
      check("done",  done,  m_done);
      check("busy4", busy4, m_active);
      check("done4", done4, m_done);
      if (!m_active) begin
        check("count16", count,  sat(m_raw, 16));
        check("ovf16",   ovf,    m_raw > 65535);
        check("count4",  count4, sat(m_raw, 4));
        check("ovf4",    ovf4,   m_raw > 15);
`ifdef OSU_SC_STUCK_DET_EN
        check("stuck",  stuck,  m_stuck);
        check("stuck4", stuck4, m_stuck);
`endif
      end
    end
  end

  int e0_tb = 0;

  task automatic do_start(input int w);
    @(negedge clk); start = 1'b1; win_len = 16'(w);
    @(negedge clk); start = 1'b0; e0_tb = cyc;
  endtask

  // Returns latency as the edge count from START to the first edge that samples DONE high.
  task automatic wait_done(output int lat, output int nbusy);
    lat = -1; nbusy = 0;
    for (int n = 0; n < 400; n++) begin
      if (done) begin lat = cyc + 1 - e0_tb; break; end
      if (busy) nbusy++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, nb, nd;
    rst = 1'b1; start = 1'b0; win_len = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  busy, 0);
    check("rst_count", count, 0);
    check("rst_ovf",   ovf, 0);
    rst = 1'b0;

    sig_period = 8;
    repeat (5) @(negedge clk);
    do_start(80); wait_done(lat, nb);
    check("t1_latency", lat, 83);
    check("t1_busy_cycles", nb, 82);
    check("t1_count", count, 10);
    check("t1_ovf", ovf, 0);

    sig_period = 4;
    repeat (3) @(negedge clk);
    do_start(0); wait_done(lat, nb);
    check("t2_latency", lat, 3);
    check("t2_busy_cycles", nb, 2);
    check("t2_count", count, 0);

    sig_period = 0; sig_level = 1'b1;
    repeat (6) @(negedge clk);
    do_start(50); wait_done(lat, nb);
    check("t3_high_count", count, 0);
    sig_level = 1'b0;
    repeat (6) @(negedge clk);
    do_start(50);
    repeat (25) @(negedge clk);
    sig_level = 1'b1;
    wait_done(lat, nb);
    check("t3_one_edge_count", count, 1);

    sig_period = 4;
    do_start(100); wait_done(lat, nb);
    check("t4_count4", count4, 15);
    check("t4_ovf4", ovf4, 1);
    check("t4_count16", count, 25);
    check("t4_ovf16", ovf, 0);
    sig_period = 0; sig_level = 1'b0;
    repeat (6) @(negedge clk);
    do_start(10); wait_done(lat, nb);
    check("t4_idle_count4", count4, 0);
    check("t4_idle_ovf4", ovf4, 0);

    sig_period = 8;
    do_start(40);
    repeat (10) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(lat, nb);
    check("t5_latency", lat, 43);
    nd = 0;
    repeat (60) begin @(negedge clk); if (done) nd++; end
    check("t5_extra_done", nd, 0);

    do_start(100);
    repeat (30) @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_count", count, 0);
    nd = 0;
    repeat (120) begin @(negedge clk); if (done) nd++; end
    check("t5_rst_no_done", nd, 0);

`ifdef OSU_SC_STUCK_DET_EN
    sig_period = 0; sig_level = 1'b0;
    repeat (6) @(negedge clk);
    do_start(100); wait_done(lat, nb);
    check("t6_stuck_const", stuck, 1);
    sig_period = 8;
    repeat (6) @(negedge clk);
    do_start(100); wait_done(lat, nb);
    check("t6_stuck_toggle", stuck, 0);
`endif

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gf180mcu_osu_sc_12t_edge_count.md
Name: gf180mcu_osu_sc_12T_edge_count

Overview:
Characterization counter that sits directly downstream of a combinational cell under test, such as an or2 chain or a ring built from library cells.
- Samples the cell output SIG in the CLK domain and counts its rising edges over a programmed window of CLK cycles.
- Reports the count with a done pulse, for on-silicon frequency/toggle characterization of library cells.
- Single clock domain; SIG is treated as asynchronous.

Parameters:
CNT_W, 16, width of edge counter and COUNT output
WIN_W, 16, width of window-length input and window counter
SYNC_STAGES, 2, synchronizer flops on SIG (legal range 2..4)
STUCK_LIMIT, 32, CLK cycles without a SIG edge before STUCK is flagged (only with the optional feature)

Ports:
CLK    input   1      clock, rising edge
RST    input   1      synchronous, active-high reset
START  input   1      request a measurement; sampled only in IDLE
WIN_LEN input  WIN_W  window length in CLK cycles; captured when START is accepted
SIG    input   1      output of cell under test, asynchronous to CLK
BUSY   output  1      high in SETTLE and COUNT
DONE   output  1      one-cycle pulse; COUNT/OVF valid
COUNT  output  CNT_W  rising edges seen in window; held until next accepted START
OVF    output  1      counter saturated during last window
STUCK  output  1      only when OSU_SC_STUCK_DET_EN is defined

Behaviour:
- Reset: on RST high at a CLK edge, state=IDLE; BUSY, DONE, OVF, STUCK, COUNT, all counters and the synchronizer chain clear to 0.
  - RST overrides everything, including mid-window; no DONE is produced for an aborted window.
- SIG path: SYNC_STAGES-flop synchronizer, then a prev flop; rise = sync_out & ~prev.
  - Edges are guaranteed detected only if SIG high and low phases each last at least 2 CLK periods; faster input is out of spec (undercount, no error).
- FSM states: IDLE, SETTLE, COUNT, DONE.
  - IDLE: START=1 → capture WIN_LEN, clear COUNT/OVF/STUCK → SETTLE. START=0 → stay.
  - SETTLE: lasts exactly SYNC_STAGES cycles to flush the synchronizer; prev tracks sync_out; no counting → COUNT. If the captured WIN_LEN==0, go to DONE instead.
  - COUNT: lasts exactly WIN_LEN cycles; each cycle with rise=1 increments the edge counter → DONE after the last window cycle.
  - DONE: DONE=1 for one cycle → IDLE.
- Timing: START sampled at edge e0 → DONE high in the cycle after edge e0+SYNC_STAGES+WIN_LEN.
- Window edges: an edge present before or at SETTLE exit is not counted. A level that is already high at window start counts 0.
- Saturation: the counter stops at 2^CNT_W-1; a further rise sets OVF, which is sticky until the next accepted START.
- Holding: START is ignored while BUSY or DONE; there is no queueing. COUNT, OVF and STUCK hold after DONE until the next accepted START.
- Window counter: loads WIN_LEN, decrements to 0, no wrap. WIN_LEN changes after capture have no effect.

Optional Feature:
OSU_SC_STUCK_DET_EN
- Defined: a stuck counter (width clog2(STUCK_LIMIT+1)) runs in COUNT only.
  - Resets to 0 on each rise; increments otherwise.
  - Reaching STUCK_LIMIT sets STUCK; sticky until the next accepted START.
  - STUCK is valid with DONE.
- Not defined: the STUCK port and its logic are absent; the port list ends at OVF.

Decomposition:
- Package gf180mcu_osu_sc_char_pkg holds:
  - state enum (IDLE, SETTLE, COUNT, DONE)
  - default width constants
  - SYNC_STAGES bounds
- Sub-module gf180mcu_osu_sc_12T_sync_rise (parameter STAGES): synchronizer chain plus prev flop, outputs rise. It is reused by later characterization blocks.

Test Plan:
- SIG period 8 CLK (4 high/4 low), WIN_LEN=80, START one cycle → DONE exactly 83 cycles after START edge (SYNC_STAGES=2), COUNT=10, OVF=0.
- WIN_LEN=0, SIG toggling → DONE 3 cycles after START, COUNT=0, BUSY high 2 cycles.
- SIG held 1 from before START, WIN_LEN=50 → COUNT=0. Then SIG 0→1 once mid-window → COUNT=1.
- CNT_W=4, SIG period 4, WIN_LEN=100 → COUNT=15, OVF=1. Next START with SIG idle, WIN_LEN=10 → COUNT=0, OVF=0.
- START pulsed again while BUSY → ignored, single DONE. RST asserted mid-COUNT → next cycle BUSY=0, COUNT=0, no DONE.
- With OSU_SC_STUCK_DET_EN, STUCK_LIMIT=32, SIG constant, WIN_LEN=100 → STUCK=1 at DONE. SIG period 8, same window → STUCK=0.
